// File: rtl/uart_resp_emulator.sv
// Multi-channel RS-485 sensor reply emulator.
// Each channel answers a falling edge on its dRX strobe with a fixed-length
// UART frame: byte 0 is a per-channel frame counter, the rest a ramp.
module uart_resp_emulator #(
  parameter int NUM_CH    = 5,
  parameter int FRAME_LEN = 20,
  parameter int BIT_DIV   = 17,
  parameter int GAP_BITS  = 30,
  parameter int STOP_BITS = 2,
  parameter int STEP      = 10
) (
  input  logic              clk80MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_mask,
  input  logic [NUM_CH-1:0] req_dRX,
  input  logic [NUM_CH-1:0] corrupt_stop,
  input  logic              ovr_clr,
  output logic [NUM_CH-1:0] uart_rx,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] frame_done,
  output logic [NUM_CH-1:0] ovr
);

  localparam int GAP_CYC  = GAP_BITS * BIT_DIV;
  localparam int STOP_CYC = STOP_BITS * BIT_DIV;
  localparam int TMAX0    = (GAP_CYC > STOP_CYC) ? GAP_CYC : STOP_CYC;
  localparam int TMAX     = (TMAX0 > BIT_DIV) ? TMAX0 : BIT_DIV;
  localparam int TW       = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_GAP      = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] T_BIT      = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] T_STOP     = TW'(STOP_CYC - 1);
  localparam logic [TW-1:0] T_LASTSTOP = TW'(BIT_DIV);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [7:0]    LAST_BYTE  = 8'(FRAME_LEN - 1);
  localparam logic [7:0]    STEP8      = 8'(STEP);

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          s1, s2, s3, fall;
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    byte_idx, byte_n;
    logic [7:0]    ramp, ramp_n;
    logic [7:0]    tx, tx_n;
    logic [7:0]    fcnt, fcnt_n;
    logic          corr, corr_n;
    logic          line_q, line_n;
    logic          busy_q, done_q;
    logic          ovr_q, ovr_n;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk80MHz or posedge rst) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        s3 <= 1'b0;
      end else begin
        s1 <= req_dRX[i];
        s2 <= s1;
        s3 <= s2;
      end
    end

    assign fall = s3 & ~s2;

    // Next-state, bit timer, byte sequencing and registered line value.
    always_comb begin
      state_n = state;
      timer_n = timer;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      ramp_n  = ramp;
      tx_n    = tx;
      fcnt_n  = fcnt;
      corr_n  = corr;
      case (state)
        IDLE: begin
          if (fall && en_mask[i]) begin
            state_n = GAP;
            timer_n = T_GAP;
            corr_n  = corrupt_stop[i];
            byte_n  = '0;
            ramp_n  = '0;
          end
        end
        GAP: begin
          if (timer == '0) begin
            state_n = START;
            timer_n = T_BIT;
            tx_n    = fcnt;
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        START: begin
          if (timer == '0) begin
            state_n = DATA;
            timer_n = T_BIT;
            bit_n   = '0;
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        DATA: begin
          if (timer == '0) begin
            if (bit_idx == 3'd7) begin
              state_n = STOP;
              timer_n = T_STOP;
            end else begin
              bit_n   = bit_idx + 3'd1;
              timer_n = T_BIT;
            end
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (byte_idx == LAST_BYTE) begin
              state_n = DONE;
            end else begin
              state_n = START;
              timer_n = T_BIT;
              byte_n  = byte_idx + 8'd1;
              ramp_n  = ramp + STEP8;
              tx_n    = ramp + STEP8;
            end
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        DONE: begin
          state_n = IDLE;
          fcnt_n  = fcnt + 8'd1;
        end
        default: state_n = IDLE;
      endcase

      // Set wins over clear when both happen in the same cycle.
      if (fall && (state != IDLE))
        ovr_n = 1'b1;
      else if (ovr_clr)
        ovr_n = 1'b0;
      else
        ovr_n = ovr_q;

      // Line follows the next state so the registered output is aligned with it.
      case (state_n)
        START:   line_n = 1'b0;
        DATA:    line_n = tx_n[bit_n];
        STOP:    line_n = ~(corr_n && (byte_n == LAST_BYTE) && (timer_n < T_LASTSTOP));
        default: line_n = 1'b1;
      endcase
    end

    // Channel state and output registers.
    always_ff @(posedge clk80MHz or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        timer    <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
        ramp     <= '0;
        tx       <= '0;
        fcnt     <= '0;
        corr     <= 1'b0;
        line_q   <= 1'b1;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        state    <= state_n;
        timer    <= timer_n;
        bit_idx  <= bit_n;
        byte_idx <= byte_n;
        ramp     <= ramp_n;
        tx       <= tx_n;
        fcnt     <= fcnt_n;
        corr     <= corr_n;
        line_q   <= line_n;
        busy_q   <= (state_n != IDLE);
        done_q   <= (state_n == DONE);
        ovr_q    <= ovr_n;
      end
    end

    assign uart_rx[i]    = line_q;
    assign busy[i]       = busy_q;
    assign frame_done[i] = done_q;
    assign ovr[i]        = ovr_q;
  end

endmodule

// File: tb/tb_uart_resp_emulator.sv
// Randomised bench for uart_resp_emulator against a cycle-level frame model.
module tb_uart_resp_emulator;

  localparam int NCH   = 5;
  localparam int FL    = 4;
  localparam int BD    = 4;
  localparam int GB    = 3;
  localparam int SB    = 2;
  localparam int ST    = 100;
  localparam int CW    = $clog2(NCH);
  localparam int GAPC  = GB * BD;
  localparam int BYTEC = (9 + SB) * BD;
  localparam int ENDO  = GAPC + FL * BYTEC;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en_mask, req, corrupt;
  logic           ovr_clr;
  logic [NCH-1:0] uart_rx, busy, frame_done, ovr;

  always #5 clk = ~clk;

  uart_resp_emulator #(
    .NUM_CH(NCH), .FRAME_LEN(FL), .BIT_DIV(BD),
    .GAP_BITS(GB), .STOP_BITS(SB), .STEP(ST)
  ) dut (
    .clk80MHz(clk), .rst(rst), .en_mask(en_mask), .req_dRX(req),
    .corrupt_stop(corrupt), .ovr_clr(ovr_clr), .uart_rx(uart_rx),
    .busy(busy), .frame_done(frame_done), .ovr(ovr)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: a frame is fully described by its start cycle,
  // the byte-0 counter value and the latched corrupt flag.
  bit             m_act  [NCH];
  int             m_start[NCH];
  bit             m_corr [NCH];
  int             m_fcnt [NCH];
  bit             m_ovr  [NCH];
  int             frames [NCH];
  logic [NCH-1:0] h0, h1, h2, h3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c]   = 1'b0;
      m_start[c] = 0;
      m_corr[c]  = 1'b0;
      m_fcnt[c]  = 0;
      m_ovr[c]   = 1'b0;
    end
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
  endfunction

  // Request latency: a drop on the pin takes effect three edges later.
  function automatic void model_step();
    bit fall, was_act;
    h3 = h2; h2 = h1; h1 = h0; h0 = req;
    for (int c = 0; c < NCH; c++) begin
      fall    = h3[CW'(c)] & ~h2[CW'(c)];
      was_act = m_act[c];
      if (fall && was_act) m_ovr[c] = 1'b1;
      else if (ovr_clr)    m_ovr[c] = 1'b0;
      if (was_act && (cyc - m_start[c] == ENDO + 1)) begin
        m_act[c]  = 1'b0;
        m_fcnt[c] = (m_fcnt[c] + 1) % 256;
        frames[c]++;
      end
      if (fall && !was_act && en_mask[CW'(c)]) begin
        m_act[c]   = 1'b1;
        m_start[c] = cyc;
        m_corr[c]  = corrupt[CW'(c)];
      end
    end
  endfunction

  function automatic logic exp_line(input int c);
    int o, k, b;
    logic [7:0] d;
    if (!m_act[c]) return 1'b1;
    o = cyc - m_start[c];
    if (o < GAPC) return 1'b1;
    o = o - GAPC;
    k = o / BYTEC;
    if (k >= FL) return 1'b1;
    b = (o % BYTEC) / BD;
    if (b == 0) return 1'b0;
    if (b <= 8) begin
      d = (k == 0) ? 8'(m_fcnt[c]) : 8'((k * ST) % 256);
      return d[3'(b - 1)];
    end
    if (m_corr[c] && (k == FL - 1) && (b == 8 + SB)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic compare_all();
    logic [NCH-1:0] erx, ebusy, edone, eovr;
    for (int c = 0; c < NCH; c++) begin
      erx[CW'(c)]   = exp_line(c);
      ebusy[CW'(c)] = m_act[c];
      edone[CW'(c)] = m_act[c] && (cyc - m_start[c] == ENDO);
      eovr[CW'(c)]  = m_ovr[c];
    end
    check("uart_rx", 32'(uart_rx), 32'(erx));
    check("busy", 32'(busy), 32'(ebusy));
    check("frame_done", 32'(frame_done), 32'(edone));
    check("ovr", 32'(ovr), 32'(eovr));
  endtask

  // Phase 0 leaves inputs alone; phase 3 lets en_mask[0] drop too.
  task automatic drive_random(input int phase);
    if (phase == 0) return;
    for (int c = 0; c < NCH; c++) begin
      if ($urandom_range(0, (c == 0) ? 7 : 15) == 0) req[CW'(c)] = ~req[CW'(c)];
    end
    if ($urandom_range(0, 31) == 0) en_mask = NCH'($urandom);
    if (phase != 3) en_mask[0] = 1'b1;
    corrupt = NCH'($urandom);
    ovr_clr = ($urandom_range(0, 31) == 0);
  endtask

  task automatic run_cycle(input int phase);
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    compare_all();
    drive_random(phase);
  endtask

  initial begin
    bit found;
    int o;
    rst = 1'b1; req = '1; en_mask = '1; corrupt = '0; ovr_clr = 1'b0;
    for (int c = 0; c < NCH; c++) frames[c] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx", 32'(uart_rx), 32'({NCH{1'b1}}));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;

    // Long random run until ch0 has wrapped its frame counter.
    while (frames[0] < 258 && cyc < 80000) run_cycle(1);
    check("ch0_wrap_reached", 32'(frames[0] >= 258), 32'd1);

    // Asynchronous reset in the middle of a data byte on ch0.
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(posedge clk);
      cyc++;
      model_step();
      o = cyc - m_start[0];
      if (m_act[0] && o >= GAPC + 2 * BYTEC + BD && o < GAPC + 2 * BYTEC + 9 * BD) begin
        found = 1'b1;
        #2 rst = 1'b1;
        req = '1;
        model_reset();
        #1;
        check("async_rst_rx", 32'(uart_rx), 32'({NCH{1'b1}}));
        check("async_rst_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
      compare_all();
      if (!found) drive_random(2);
    end
    check("rst_point_found", 32'(found), 32'd1);
    run_cycle(0);
    run_cycle(0);
    rst = 1'b0;
    en_mask = '1;
    corrupt = '0;
    ovr_clr = 1'b0;

    // Fresh request after reset: byte 0 must restart from zero.
    run_cycle(0);
    req[0] = 1'b0;
    run_cycle(0);
    req[0] = 1'b1;
    repeat (ENDO + 10) run_cycle(0);

    // Fully random including en_mask drops on every channel.
    repeat (3000) run_cycle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
